// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer and its forwarding matcher.
package store_buffer_pkg;

    localparam int unsigned ADDR_LEN  = 32;
    localparam int unsigned DATA_LEN  = 32;
    localparam int unsigned STB_DEPTH = 4;
    localparam int unsigned STB_SEL   = $clog2(STB_DEPTH);

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Store-to-load forwarding matcher: finds the youngest valid entry whose word
// address equals the load's word address. Ages are measured relative to tail.
module store_buffer_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STB_DEPTH,
    localparam int unsigned SelW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]               valid_i,
    input  logic [DEPTH-1:0][ADDR_LEN-3:0] waddr_i,
    input  logic [SelW-1:0]                tail_i,
    input  logic [ADDR_LEN-3:0]            ld_waddr_i,
    output logic                           hit_o,
    output logic [SelW-1:0]                idx_o
);

    // Scan oldest (tail - DEPTH) to youngest (tail - 1); the last match wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid_i[tail_i - SelW'(k)] && (waddr_i[tail_i - SelW'(k)] == ld_waddr_i)) begin
                hit_o = 1'b1;
                idx_o = tail_i - SelW'(k);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds executed stores until the ROB commits them, drains
// committed stores in order to dmem, and forwards buffered data to loads.
// Forwarding is built only when STORE_BUFFER_FWD_EN is defined; otherwise
// ld_hit_o/ld_data_o are tied to 0 and loads must wait for empty_o.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STB_DEPTH,
    localparam int unsigned SelW = $clog2(DEPTH),
    localparam int unsigned CntW = SelW + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                st_we_i,
    input  logic [ADDR_LEN-1:0] st_addr_i,
    input  logic [DATA_LEN-1:0] st_data_i,
    output logic                full_o,
    input  logic                commit_st_i,
    input  logic                flush_i,
    input  logic [ADDR_LEN-1:0] ld_addr_i,
    output logic                ld_hit_o,
    output logic [DATA_LEN-1:0] ld_data_o,
    output logic                dmem_we_o,
    output logic [ADDR_LEN-1:0] dmem_waddr_o,
    output logic [DATA_LEN-1:0] dmem_wdata_o,
    output logic                empty_o,
    output logic [CntW-1:0]     count_o
);

    logic [DEPTH-1:0][ADDR_LEN-1:0] addr_q;
    logic [DEPTH-1:0][DATA_LEN-1:0] data_q;
    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [SelW-1:0]                head_q, head_d;
    logic [SelW-1:0]                cptr_q, cptr_d;
    logic [SelW-1:0]                tail_q, tail_d;
    logic [CntW-1:0]                count_q, count_d;
    logic [CntW-1:0]                ccount_q, ccount_d;

    logic full, drain, commit, alloc;

    assign full   = (count_q == CntW'(DEPTH));
    assign drain  = (ccount_q != '0);
    // Uses pre-edge counts, so a store allocated this cycle is never committable.
    assign commit = commit_st_i && (count_q > ccount_q);
    assign alloc  = st_we_i && !full && !flush_i;

    // Next-state: drain, then commit, then flush, then allocate.
    always_comb begin
        valid_d  = valid_q;
        head_d   = head_q;
        cptr_d   = cptr_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ccount_d = ccount_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + SelW'(1);
            count_d         = count_d - CntW'(1);
            ccount_d        = ccount_d - CntW'(1);
        end
        if (commit) begin
            cptr_d   = cptr_q + SelW'(1);
            ccount_d = ccount_d + CntW'(1);
        end
        if (flush_i) begin
            // Uncommitted entries occupy [cptr_d, cptr_d + count_d - ccount_d).
            for (int k = 0; k < DEPTH; k++) begin
                if (CntW'(k) < (count_d - ccount_d)) begin
                    valid_d[cptr_d + SelW'(k)] = 1'b0;
                end
            end
            tail_d  = cptr_d;
            count_d = ccount_d;
        end else if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + SelW'(1);
            count_d         = count_d + CntW'(1);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q  <= '0;
            head_q   <= '0;
            cptr_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ccount_q <= '0;
        end else begin
            valid_q  <= valid_d;
            head_q   <= head_d;
            cptr_q   <= cptr_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ccount_q <= ccount_d;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (!reset_i && alloc) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
        end
    end

    assign full_o       = full;
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign dmem_we_o    = drain;
    assign dmem_waddr_o = drain ? addr_q[head_q] : '0;
    assign dmem_wdata_o = drain ? data_q[head_q] : '0;

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0][ADDR_LEN-3:0] entry_waddr;
    logic                           fwd_hit;
    logic [SelW-1:0]                fwd_idx;
    logic                           unused_ld_lo;

    // Word addresses of every entry for the matcher.
    always_comb begin
        entry_waddr = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entry_waddr[k] = addr_q[k][ADDR_LEN-1:2];
        end
    end

    store_buffer_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .valid_i    (valid_q),
        .waddr_i    (entry_waddr),
        .tail_i     (tail_q),
        .ld_waddr_i (ld_addr_i[ADDR_LEN-1:2]),
        .hit_o      (fwd_hit),
        .idx_o      (fwd_idx)
    );

    assign ld_hit_o     = fwd_hit;
    assign ld_data_o    = fwd_hit ? data_q[fwd_idx] : '0;
    assign unused_ld_lo = ^ld_addr_i[1:0];
`else
    logic unused_ld_addr;

    assign ld_hit_o       = 1'b0;
    assign ld_data_o      = '0;
    assign unused_ld_addr = ^ld_addr_i;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer. Each row drives one cycle of
// inputs and lists the outputs expected while those inputs are applied.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_i, st_we_i, commit_st_i, flush_i;
    logic [ADDR_LEN-1:0] st_addr_i, ld_addr_i;
    logic [DATA_LEN-1:0] st_data_i;
    logic                full_o, ld_hit_o, dmem_we_o, empty_o;
    logic [DATA_LEN-1:0] ld_data_o, dmem_wdata_o;
    logic [ADDR_LEN-1:0] dmem_waddr_o;
    logic [STB_SEL:0]    count_o;

    store_buffer dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .st_we_i      (st_we_i),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .full_o       (full_o),
        .commit_st_i  (commit_st_i),
        .flush_i      (flush_i),
        .ld_addr_i    (ld_addr_i),
        .ld_hit_o     (ld_hit_o),
        .ld_data_o    (ld_data_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_waddr_o (dmem_waddr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .empty_o      (empty_o),
        .count_o      (count_o)
    );

    typedef struct {
        logic        rst, we;
        logic [31:0] addr, data;
        logic        cm, fl;
        logic [31:0] ld;
        logic        full, empty;
        logic [2:0]  cnt;
        logic        dwe;
        logic [31:0] waddr, wdata;
        logic        hit;
        logic [31:0] ldata;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    task automatic add(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic cm, input logic fl,
                       input logic [31:0] ld, input logic full, input logic empty,
                       input logic [2:0] cnt, input logic dwe, input logic [31:0] wa,
                       input logic [31:0] wd, input logic hit, input logic [31:0] ldd);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = a; v.data = d; v.cm = cm; v.fl = fl; v.ld = ld;
        v.full = full; v.empty = empty; v.cnt = cnt; v.dwe = dwe; v.waddr = wa;
        v.wdata = wd; v.hit = hit; v.ldata = ldd;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL: timeout waiting for the directed sequence to finish");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        logic        exp_hit;
        logic [31:0] exp_ld;

        reset_i = 1'b1; st_we_i = 1'b0; commit_st_i = 1'b0; flush_i = 1'b0;
        st_addr_i = '0; st_data_i = '0; ld_addr_i = '0;

        //   rst we addr   data   cm fl ld       full emp cnt we waddr  wdata  hit ldata
        // Reset, single store, commit, drain.
        add(1, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h100,  'h11,  0, 0, 'h100,   0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 'h100,   0, 0, 1, 0, 0,      0,     1, 'h11);
        add(0, 0, 0,      0,     0, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 'h100,   0, 0, 1, 1, 'h100,  'h11,  1, 'h11);
        add(0, 0, 0,      0,     0, 0, 'h100,   0, 1, 0, 0, 0,      0,     0, 0);
        // Fill to full, refused 5th store, four commits drained in order.
        add(1, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h300,  1,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h304,  2,     0, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 1, 'h308,  3,     0, 0, 0,       0, 0, 2, 0, 0,      0,     0, 0);
        add(0, 1, 'h30C,  4,     0, 0, 0,       0, 0, 3, 0, 0,      0,     0, 0);
        add(0, 1, 'h310,  5,     0, 0, 'h30C,   1, 0, 4, 0, 0,      0,     1, 4);
        add(0, 0, 0,      0,     0, 0, 'h310,   1, 0, 4, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       1, 0, 4, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       1, 0, 4, 1, 'h300,  1,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 3, 1, 'h304,  2,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 2, 1, 'h308,  3,     0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 0, 1, 1, 'h30C,  4,     0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        // Forwarding picks the youngest of two same-address stores.
        add(0, 1, 'h200,  'hAA,  0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h200,  'hBB,  0, 0, 'h200,   0, 0, 1, 0, 0,      0,     1, 'hAA);
        add(0, 0, 0,      0,     0, 0, 'h200,   0, 0, 2, 0, 0,      0,     1, 'hBB);
        add(0, 0, 0,      0,     0, 0, 'h204,   0, 0, 2, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 'h203,   0, 0, 2, 0, 0,      0,     1, 'hBB);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 2, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 2, 1, 'h200,  'hAA,  0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 0, 1, 1, 'h200,  'hBB,  0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        // Three stores, commit one, then flush with commit and a dropped store.
        add(0, 1, 'h400,  'h41,  0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h404,  'h42,  0, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 1, 'h408,  'h43,  0, 0, 0,       0, 0, 2, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 3, 0, 0,      0,     0, 0);
        add(0, 1, 'h40C,  'h44,  1, 1, 0,       0, 0, 3, 1, 'h400,  'h41,  0, 0);
        add(0, 0, 0,      0,     0, 0, 'h408,   0, 0, 1, 1, 'h404,  'h42,  0, 0);
        add(0, 0, 0,      0,     0, 0, 'h40C,   0, 1, 0, 0, 0,      0,     0, 0);
        // Next store lands at the flushed slot and drains from there.
        add(0, 1, 'h500,  'h51,  0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 0, 1, 1, 'h500,  'h51,  0, 0);
        add(0, 0, 0,      0,     0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        // Full with one committed: store refused while drain frees a slot.
        add(0, 1, 'h600,  'h61,  0, 0, 0,       0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 1, 'h604,  'h62,  0, 0, 0,       0, 0, 1, 0, 0,      0,     0, 0);
        add(0, 1, 'h608,  'h63,  0, 0, 0,       0, 0, 2, 0, 0,      0,     0, 0);
        add(0, 1, 'h60C,  'h64,  0, 0, 0,       0, 0, 3, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       1, 0, 4, 0, 0,      0,     0, 0);
        add(0, 1, 'h610,  'h65,  0, 0, 0,       1, 0, 4, 1, 'h600,  'h61,  0, 0);
        add(0, 1, 'h604,  'h99,  0, 0, 'h610,   0, 0, 3, 0, 0,      0,     0, 0);
        // Youngest match across the pointer wrap.
        add(0, 0, 0,      0,     0, 0, 'h604,   1, 0, 4, 0, 0,      0,     1, 'h99);
        // Reset in the middle of a drain, then reset overriding every input.
        add(0, 0, 0,      0,     1, 0, 0,       1, 0, 4, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       1, 0, 4, 1, 'h604,  'h62,  0, 0);
        add(0, 0, 0,      0,     1, 0, 0,       0, 0, 3, 1, 'h608,  'h63,  0, 0);
        add(1, 0, 0,      0,     0, 0, 'h604,   0, 0, 2, 1, 'h60C,  'h64,  1, 'h99);
        add(1, 1, 'h700,  'h77,  1, 0, 'h604,   0, 1, 0, 0, 0,      0,     0, 0);
        add(0, 0, 0,      0,     0, 0, 'h700,   0, 1, 0, 0, 0,      0,     0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_i     = vecs[i].rst;
            st_we_i     = vecs[i].we;
            st_addr_i   = vecs[i].addr;
            st_data_i   = vecs[i].data;
            commit_st_i = vecs[i].cm;
            flush_i     = vecs[i].fl;
            ld_addr_i   = vecs[i].ld;
            #1;
            if (i == 1) begin
                checks++;
                if (full_o !== 1'b0 || empty_o !== 1'b1 || count_o !== '0 ||
                    dmem_we_o !== 1'b0 || dmem_waddr_o !== '0 || dmem_wdata_o !== '0 ||
                    ld_hit_o !== 1'b0 || ld_data_o !== '0) begin
                    errors++;
                    $display("FAIL reset state: full=%0b empty=%0b cnt=%0d we=%0b wa=%h wd=%h hit=%0b ld=%h",
                             full_o, empty_o, count_o, dmem_we_o, dmem_waddr_o,
                             dmem_wdata_o, ld_hit_o, ld_data_o);
                end
            end
            if (i != 0) begin
                exp_hit = vecs[i].hit;
                exp_ld  = vecs[i].ldata;
`ifndef STORE_BUFFER_FWD_EN
                exp_hit = 1'b0;
                exp_ld  = '0;
`endif
                checks++;
                if ({full_o, empty_o, count_o, dmem_we_o, dmem_waddr_o, dmem_wdata_o,
                     ld_hit_o, ld_data_o} !==
                    {vecs[i].full, vecs[i].empty, vecs[i].cnt, vecs[i].dwe, vecs[i].waddr,
                     vecs[i].wdata, exp_hit, exp_ld}) begin
                    errors++;
                    $display("FAIL row%0d: got full=%0b empty=%0b cnt=%0d we=%0b wa=%h wd=%h hit=%0b ld=%h; want full=%0b empty=%0b cnt=%0d we=%0b wa=%h wd=%h hit=%0b ld=%h",
                             i, full_o, empty_o, count_o, dmem_we_o, dmem_waddr_o,
                             dmem_wdata_o, ld_hit_o, ld_data_o, vecs[i].full, vecs[i].empty,
                             vecs[i].cnt, vecs[i].dwe, vecs[i].waddr, vecs[i].wdata,
                             exp_hit, exp_ld);
                end
            end
        end

        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
